// File: rtl/ex_pkg.sv
// ex_pkg: shared types and helpers for the RV64 execute stage.
//   - alu_op encodings from decode
//   - 4-bit ALU control codes
//   - forwarding select codes
//   - alu_decode(): alu_op/funct3/funct7b5 -> ALU control
package ex_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_RTYPE = 2'b10,
        ALU_OP_ITYPE = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_sel_e;

    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic       funct7b5);
        alu_ctrl_e ctrl;
        ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: ctrl = ALU_ADD;
            ALU_OP_SUB: ctrl = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000: begin
                        // I-type has no SUB; bit 30 is part of the immediate there.
                        if (alu_op == ALU_OP_RTYPE && funct7b5) ctrl = ALU_SUB;
                        else                                    ctrl = ALU_ADD;
                    end
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/ex_forward_unit.sv
// ex_forward_unit: combinational operand-forwarding select.
//   Build option: FORWARDING_EN. When undefined both selects are FWD_RF and
//   the hazard unit is expected to stall instead.
// Ports:
//   rs1, rs2          in   source register indices of the EX instruction
//   exmem_reg_write   in   EX/MEM instruction writes a register
//   exmem_rd          in   EX/MEM destination
//   wb_reg_write      in   MEM/WB instruction writes a register
//   wb_rd             in   MEM/WB destination
//   forward_a/b       out  operand select (fwd_sel_e)
module ex_forward_unit
    import ex_pkg::*;
(
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b
);

`ifdef FORWARDING_EN
    // EX/MEM is checked first: it holds the younger, more recent value.
    function automatic logic [1:0] sel(input logic [REG_W-1:0] rs,
                                       input logic             ex_we,
                                       input logic [REG_W-1:0] ex_rd,
                                       input logic             wb_we,
                                       input logic [REG_W-1:0] wb_dst);
        logic [1:0] s;
        s = FWD_RF;
        if (ex_we && ex_rd != '0 && ex_rd == rs)         s = FWD_EXMEM;
        else if (wb_we && wb_dst != '0 && wb_dst == rs)  s = FWD_WB;
        return s;
    endfunction

    always_comb begin
        forward_a = sel(rs1, exmem_reg_write, exmem_rd, wb_reg_write, wb_rd);
        forward_b = sel(rs2, exmem_reg_write, exmem_rd, wb_reg_write, wb_rd);
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs1, rs2, exmem_reg_write, exmem_rd, wb_reg_write, wb_rd};
    assign forward_a = FWD_RF;
    assign forward_b = FWD_RF;
`endif

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: RV64 execute stage with the EX/MEM pipeline register.
//   Build option: FORWARDING_EN enables EX/MEM and MEM/WB operand forwarding.
// Ports:
//   clk, rst                       clock, async active-low reset
//   pc, rs1_data, rs2_data, imm    ID/EX operands (64 bit)
//   rs1, rs2, rd                   ID/EX register indices
//   alu_op, funct3, funct7b5       ALU control inputs
//   alu_src                        operand B = imm
//   branch .. reg_write            ID/EX control bits
//   flush                          squash: control bits of EX/MEM load 0
//   wb_reg_write, wb_rd, wb_data   MEM/WB writeback source
//   forward_a, forward_b           debug view of forwarding selects
//   *_q                            EX/MEM register outputs
module ex_mem_pipe
    import ex_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic [XLEN-1:0]  imm,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic [REG_W-1:0] rd,
    input  logic [1:0]       alu_op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             alu_src,
    input  logic             branch,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_to_reg,
    input  logic             reg_write,
    input  logic             flush,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic             mem_to_reg_q,
    output logic             reg_write_q,
    output logic             branch_q,
    output logic             mem_read_q,
    output logic             mem_write_q,
    output logic [XLEN-1:0]  pc_branch_q,
    output logic [XLEN-1:0]  alu_result_q,
    output logic [XLEN-1:0]  rs2_data_q,
    output logic             alu_zero_q,
    output logic [REG_W-1:0] rd_q
);

    logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_result, pc_branch;
    logic [5:0]      shamt;
    alu_ctrl_e       alu_ctrl;

    ex_forward_unit u_forward (
        .rs1             (rs1),
        .rs2             (rs2),
        .exmem_reg_write (reg_write_q),
        .exmem_rd        (rd_q),
        .wb_reg_write    (wb_reg_write),
        .wb_rd           (wb_rd),
        .forward_a       (forward_a),
        .forward_b       (forward_b)
    );

    always_comb begin
        case (forward_a)
            FWD_EXMEM: fwd_rs1 = alu_result_q;
            FWD_WB:    fwd_rs1 = wb_data;
            default:   fwd_rs1 = rs1_data;
        endcase
        case (forward_b)
            FWD_EXMEM: fwd_rs2 = alu_result_q;
            FWD_WB:    fwd_rs2 = wb_data;
            default:   fwd_rs2 = rs2_data;
        endcase
    end

    assign op_a      = fwd_rs1;
    assign op_b      = alu_src ? imm : fwd_rs2;
    assign shamt     = op_b[5:0];
    assign alu_ctrl  = alu_decode(alu_op, funct3, funct7b5);
    assign pc_branch = pc + imm;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:  alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            branch_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            pc_branch_q  <= '0;
            alu_result_q <= '0;
            rs2_data_q   <= '0;
            alu_zero_q   <= 1'b0;
            rd_q         <= '0;
        end else begin
            // A flush turns the instruction into a bubble; data fields are don't-care.
            mem_to_reg_q <= mem_to_reg & ~flush;
            reg_write_q  <= reg_write & ~flush;
            branch_q     <= branch & ~flush;
            mem_read_q   <= mem_read & ~flush;
            mem_write_q  <= mem_write & ~flush;
            pc_branch_q  <= pc_branch;
            alu_result_q <= alu_result;
            rs2_data_q   <= fwd_rs2;
            alu_zero_q   <= (alu_result == '0);
            rd_q         <= rd;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst;
    logic [63:0] pc, rs1_data, rs2_data, imm, wb_data;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5, alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write;
    logic        flush, wb_reg_write;
    logic [1:0]  forward_a, forward_b;
    logic        mem_to_reg_q, reg_write_q, branch_q, mem_read_q, mem_write_q, alu_zero_q;
    logic [63:0] pc_branch_q, alu_result_q, rs2_data_q;
    logic [4:0]  rd_q;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .rs1(rs1), .rs2(rs2), .rd(rd), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
        .alu_src(alu_src), .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .flush(flush),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .forward_a(forward_a), .forward_b(forward_b),
        .mem_to_reg_q(mem_to_reg_q), .reg_write_q(reg_write_q), .branch_q(branch_q),
        .mem_read_q(mem_read_q), .mem_write_q(mem_write_q), .pc_branch_q(pc_branch_q),
        .alu_result_q(alu_result_q), .rs2_data_q(rs2_data_q), .alu_zero_q(alu_zero_q),
        .rd_q(rd_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [63:0] alu;
        logic        zero;
        logic [63:0] pcb;
        logic [63:0] rs2q;
        logic [4:0]  rd;
        logic [4:0]  ctrl;  // {mem_to_reg, reg_write, branch, mem_read, mem_write}
    } exp_t;

    exp_t q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after a rising edge, well clear of the edge.
    task automatic step();
        @(posedge clk);
        #2;
        pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; wb_data = '0;
        rs1 = '0; rs2 = '0; rd = '0; wb_rd = '0; alu_op = '0; funct3 = '0;
        funct7b5 = 0; alu_src = 0; branch = 0; mem_read = 0; mem_write = 0;
        mem_to_reg = 0; reg_write = 0; flush = 0; wb_reg_write = 0;
    endtask

    task automatic expect_out(input logic [1:0] fa, input logic [1:0] fb,
                              input logic [63:0] alu, input logic zero,
                              input logic [63:0] pcb, input logic [63:0] rs2q);
        exp_t e;
        e.fa   = fa;
        e.fb   = fb;
        e.alu  = rst ? alu : '0;
        e.zero = rst ? zero : 1'b0;
        e.pcb  = rst ? pcb : '0;
        e.rs2q = rst ? rs2q : '0;
        e.rd   = rst ? rd : '0;
        e.ctrl = (rst && !flush) ? {mem_to_reg, reg_write, branch, mem_read, mem_write} : '0;
        q.push_back(e);
    endtask

    // Monitor: forward selects at the falling edge, EX/MEM outputs 1 unit after the next rise.
    initial begin
        exp_t cur;
        bit   have;
        forever begin
            @(negedge clk);
            have = 0;
            if (q.size() > 0) begin
                cur  = q.pop_front();
                have = 1;
                chk("forward_a", {62'b0, forward_a}, {62'b0, cur.fa});
                chk("forward_b", {62'b0, forward_b}, {62'b0, cur.fb});
            end
            @(posedge clk);
            #1;
            if (have) begin
                chk("alu_result_q", alu_result_q, cur.alu);
                chk("alu_zero_q", {63'b0, alu_zero_q}, {63'b0, cur.zero});
                chk("pc_branch_q", pc_branch_q, cur.pcb);
                chk("rs2_data_q", rs2_data_q, cur.rs2q);
                chk("rd_q", {59'b0, rd_q}, {59'b0, cur.rd});
                chk("ctrl_q", {59'b0, mem_to_reg_q, reg_write_q, branch_q, mem_read_q,
                               mem_write_q}, {59'b0, cur.ctrl});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0;
        // Reset with random operands and all controls asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            pc = {$urandom, $urandom}; rs1_data = {$urandom, $urandom};
            rs2_data = {$urandom, $urandom}; imm = {$urandom, $urandom};
            rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom | 1);
            alu_op = 2'($urandom); funct3 = 3'($urandom); alu_src = 1'($urandom);
            branch = 1; mem_read = 1; mem_write = 1; mem_to_reg = 1; reg_write = 1;
            expect_out(2'b00, 2'b00, '0, 1'b0, '0, '0);
        end

        // R-type SUB 10-3, first edge after reset release.
        step(); rst = 1;
        rs1 = 1; rs2 = 2; rd = 3; rs1_data = 10; rs2_data = 3;
        alu_op = 2'b10; funct3 = 3'b000; funct7b5 = 1; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'd7, 1'b0, 64'd0, 64'd3);

        // addi x5 = 20
        step(); pc = 64'h40; rd = 5; imm = 20; alu_src = 1; alu_op = 2'b11; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'd20, 1'b0, 64'h54, 64'd0);

        // x5 + 1 with x5 in EX/MEM
        step(); pc = 64'h44; rs1 = 5; imm = 1; alu_src = 1; alu_op = 2'b11; rd = 6;
        reg_write = 1;
        expect_out(FWD ? 2'b10 : 2'b00, 2'b00, FWD ? 64'd21 : 64'd1, 1'b0, 64'h45, 64'd0);

        // addi x5 = 7
        step(); rd = 5; imm = 7; alu_src = 1; alu_op = 2'b11; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'd7, 1'b0, 64'd7, 64'd0);

        // x1(100) - x5: EX/MEM (7) beats MEM/WB (99)
        step(); rs1 = 1; rs1_data = 100; rs2 = 5; rs2_data = 1; alu_op = 2'b01; rd = 7;
        wb_reg_write = 1; wb_rd = 5; wb_data = 99;
        expect_out(2'b00, FWD ? 2'b10 : 2'b00, FWD ? 64'd93 : 64'd99, 1'b0, 64'd0,
                   FWD ? 64'd7 : 64'd1);

        // x5 + 1 with only MEM/WB matching
        step(); rs1 = 5; rs1_data = 2; imm = 1; alu_src = 1; alu_op = 2'b00; rd = 8;
        reg_write = 1; wb_reg_write = 1; wb_rd = 5; wb_data = 99;
        expect_out(FWD ? 2'b01 : 2'b00, 2'b00, FWD ? 64'd100 : 64'd3, 1'b0, 64'd1, 64'd0);

        // write to x0 (rd_q becomes 0 with reg_write_q=1)
        step(); rs1 = 9; rs1_data = 5; rs2 = 10; rs2_data = 6; rd = 0; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'd11, 1'b0, 64'd0, 64'd6);

        // rs=x0 with rd_q=0 and wb_rd=0: never forwarded
        step(); rs1_data = 3; rs2_data = 4; wb_reg_write = 1; wb_rd = 0; wb_data = 99; rd = 1;
        expect_out(2'b00, 2'b00, 64'd7, 1'b0, 64'd0, 64'd4);

        // BEQ-style compare, taken
        step(); pc = 64'h100; imm = -64'sd8; rs1 = 11; rs2 = 12; rs1_data = 4; rs2_data = 4;
        alu_op = 2'b01; branch = 1;
        expect_out(2'b00, 2'b00, 64'd0, 1'b1, 64'hF8, 64'd4);

        // same, flushed: controls squashed, data loads
        step(); pc = 64'h100; imm = -64'sd8; rs1 = 11; rs2 = 12; rs1_data = 4; rs2_data = 4;
        alu_op = 2'b01; branch = 1; reg_write = 1; mem_write = 1; flush = 1;
        expect_out(2'b00, 2'b00, 64'd0, 1'b1, 64'hF8, 64'd4);

        // SRA -16 >> 2
        step(); rs1 = 13; rs2 = 14; rs1_data = -64'sd16; rs2_data = 2; alu_op = 2'b10;
        funct3 = 3'b101; funct7b5 = 1; rd = 3;
        expect_out(2'b00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 64'd2);

        // SRL -16 >> 2
        step(); rs1 = 13; rs2 = 14; rs1_data = -64'sd16; rs2_data = 2; alu_op = 2'b10;
        funct3 = 3'b101; rd = 3;
        expect_out(2'b00, 2'b00, 64'h3FFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 64'd2);

        // SLT -1 < 1
        step(); rs1 = 13; rs2 = 14; rs1_data = -64'sd1; rs2_data = 1; alu_op = 2'b10;
        funct3 = 3'b010; rd = 3;
        expect_out(2'b00, 2'b00, 64'd1, 1'b0, 64'd0, 64'd1);

        // SLTU 0xFF..FF < 1
        step(); rs1 = 13; rs2 = 14; rs1_data = -64'sd1; rs2_data = 1; alu_op = 2'b10;
        funct3 = 3'b011; rd = 3;
        expect_out(2'b00, 2'b00, 64'd0, 1'b1, 64'd0, 64'd1);

        // SLL uses only B[5:0]: 1 << (67 & 63)
        step(); rs1 = 13; rs2 = 14; rs1_data = 1; rs2_data = 67; alu_op = 2'b10;
        funct3 = 3'b001; rd = 3;
        expect_out(2'b00, 2'b00, 64'd8, 1'b0, 64'd0, 64'd67);

        // I-type XOR / ADD (funct7b5 ignored) / OR / AND
        step(); rs1 = 13; rs1_data = 64'hF0; imm = 64'hFF; alu_src = 1; alu_op = 2'b11;
        funct3 = 3'b100; rd = 15; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'h0F, 1'b0, 64'hFF, 64'd0);
        step(); rs1 = 13; rs1_data = 5; imm = 3; alu_src = 1; alu_op = 2'b11;
        funct3 = 3'b000; funct7b5 = 1; rd = 15; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'd8, 1'b0, 64'd3, 64'd0);
        step(); rs1 = 13; rs1_data = 64'hF0; imm = 64'h0F; alu_src = 1; alu_op = 2'b11;
        funct3 = 3'b110; rd = 15; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'hFF, 1'b0, 64'h0F, 64'd0);
        step(); rs1 = 13; rs1_data = 64'hF0; imm = 64'h3C; alu_src = 1; alu_op = 2'b11;
        funct3 = 3'b111; rd = 15; reg_write = 1;
        expect_out(2'b00, 2'b00, 64'h30, 1'b0, 64'h3C, 64'd0);

        // Drain the scoreboard, bounded.
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-cycle clears registers without a clock edge.
        #3;
        rst = 0;
        #1;
        chk("async_rst alu_result_q", alu_result_q, 64'd0);
        chk("async_rst rd_q", {59'b0, rd_q}, 64'd0);
        chk("async_rst reg_write_q", {63'b0, reg_write_q}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
